// File: rtl/capsense_pkg.sv
// ----------------------------------------------------------------------------
// capsense_pkg
// Shared types and constants for the capacitive-sense scan controller.
//   state_t    : scan FSM states (IDLE, DISCH, CHARGE, RECORD)
//   DEF_*      : default parameter values used by capsense_scan_ctrl
//   idx_width  : channel-index width, never less than one bit
// ----------------------------------------------------------------------------
package capsense_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DISCH  = 2'd1,
        CHARGE = 2'd2,
        RECORD = 2'd3
    } state_t;

    localparam int DEF_N           = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_DISCH_TICKS = 4;
    localparam int DEF_THRESH      = 8;
    localparam int DEF_CAL_ROUNDS  = 2;
    localparam int DEF_DEB         = 3;

    // A single pad still needs a one-bit channel index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/capsense_debounce.sv
// ----------------------------------------------------------------------------
// capsense_debounce
// Per-channel debouncer. Each update strobe compares the raw press decision
// with the current flag; DEB consecutive disagreeing updates flip the flag.
// An agreeing update clears the run.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   update  : one-cycle strobe, raw is valid
//   raw     : raw press decision for this measurement
//   pressed : debounced press flag
// ----------------------------------------------------------------------------
module capsense_debounce #(
    parameter int DEB = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic update,
    input  logic raw,
    output logic pressed
);

    localparam int DW = $clog2(DEB + 1);

    logic [DW-1:0] deb_reg;
    logic          pressed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_reg     <= '0;
            pressed_reg <= 1'b0;
        end else if (update) begin
            if (raw != pressed_reg) begin
                // This update is the DEB-th disagreement in a row.
                if (deb_reg == DW'(DEB - 1)) begin
                    pressed_reg <= ~pressed_reg;
                    deb_reg     <= '0;
                end else begin
                    deb_reg <= deb_reg + 1'b1;
                end
            end else begin
                deb_reg <= '0;
            end
        end
    end

    assign pressed = pressed_reg;

endmodule

// File: rtl/capsense_scan_ctrl.sv
// ----------------------------------------------------------------------------
// capsense_scan_ctrl
// Round-robin scan scheduler for N capacitive-sense pads. Each pad in turn is
// discharged for DISCH_TICKS sample ticks, released, and the ticks until its
// input reads high are counted. The first CAL_ROUNDS rounds after reset set a
// per-channel baseline (minimum count); afterwards a count more than THRESH
// above baseline is a raw press, debounced over DEB rounds.
//
// Optional feature (macro CAPSENSE_BASELINE_TRACK_EN): after calibration, an
// unpressed channel with raw=0 moves its baseline one count toward each new
// measurement to follow slow drift. Undefined: baselines frozen.
//
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   ena_i          : one-cycle sample tick
//   enable_i       : scan continuously while high (checked at round end)
//   capsense_i     : synchronized pad inputs
//   capsense_oe_o  : per-pad drive-low enable (1 = discharge)
//   pressed_o      : debounced press flags
//   cnt_o/cnt_ch_o : last count and its channel, strobed by cnt_valid_o
//   timeout_o      : sticky, a charge reached the counter maximum
//   cal_done_o     : calibration complete
//   busy_o         : FSM not idle
// ----------------------------------------------------------------------------
module capsense_scan_ctrl
    import capsense_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DISCH_TICKS = DEF_DISCH_TICKS,
    parameter int THRESH      = DEF_THRESH,
    parameter int CAL_ROUNDS  = DEF_CAL_ROUNDS,
    parameter int DEB         = DEF_DEB
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ena_i,
    input  logic                    enable_i,
    input  logic [N-1:0]            capsense_i,
    output logic [N-1:0]            capsense_oe_o,
    output logic [N-1:0]            pressed_o,
    output logic [CNT_W-1:0]        cnt_o,
    output logic [idx_width(N)-1:0] cnt_ch_o,
    output logic                    cnt_valid_o,
    output logic                    timeout_o,
    output logic                    cal_done_o,
    output logic                    busy_o
);

    localparam int CH_W = idx_width(N);
    localparam int TW   = $clog2(DISCH_TICKS + 1);
    localparam int RW   = $clog2(CAL_ROUNDS + 1);

    state_t             state_reg;
    logic [CH_W-1:0]    ch_reg;
    logic [TW-1:0]      tick_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [N-1:0]       oe_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CH_W-1:0]    cnt_ch_reg;
    logic               valid_reg;
    logic               timeout_reg;
    logic               cal_done_reg;
    logic               busy_reg;
    logic [RW-1:0]      round_reg;

    logic [N-1:0][CNT_W-1:0] baseline_vec;
    logic [N-1:0]            pressed_vec;

    logic               charge_tick;
    logic               pad_high;
    logic               hit;
    logic               sat;
    logic               record_fire;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   count_fin;
    logic [CNT_W-1:0]   baseline_cur;
    logic [CNT_W:0]     limit;
    logic               raw_cur;
    logic               last_ch;

    // A measurement completes on the tick that sees the pad high (that tick is
    // not counted) or on the tick that would bring the count to its maximum.
    assign charge_tick = (state_reg == CHARGE) && ena_i;
    assign pad_high    = capsense_i[ch_reg];
    assign count_inc   = count_reg + 1'b1;
    assign hit         = charge_tick && pad_high;
    assign sat         = charge_tick && !pad_high && (count_inc == '1);
    assign record_fire = hit || sat;
    assign count_fin   = hit ? count_reg : count_inc;
    assign last_ch     = (ch_reg == CH_W'(N - 1));

    // Threshold sum carries one extra bit so a high baseline cannot wrap.
    assign baseline_cur = baseline_vec[ch_reg];
    assign limit        = {1'b0, baseline_cur} + (CNT_W + 1)'(THRESH);
    assign raw_cur      = ({1'b0, count_fin} > limit);

    // Scan FSM. All result outputs are registered on the completing tick so
    // they are presented together during the RECORD cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            ch_reg       <= '0;
            tick_reg     <= '0;
            count_reg    <= '0;
            oe_reg       <= '1;
            cnt_reg      <= '0;
            cnt_ch_reg   <= '0;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            cal_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
            round_reg    <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable_i) begin
                        state_reg <= DISCH;
                        ch_reg    <= '0;
                        tick_reg  <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                DISCH: begin
                    if (ena_i) begin
                        if (tick_reg == TW'(DISCH_TICKS - 1)) begin
                            state_reg <= CHARGE;
                            tick_reg  <= '0;
                            count_reg <= '0;
                            oe_reg    <= ~(N'(1) << ch_reg);
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
                CHARGE: begin
                    if (record_fire) begin
                        state_reg  <= RECORD;
                        oe_reg     <= '1;
                        cnt_reg    <= count_fin;
                        cnt_ch_reg <= ch_reg;
                        valid_reg  <= 1'b1;
                        if (sat) begin
                            timeout_reg <= 1'b1;
                        end
                        if (last_ch) begin
                            if (round_reg != RW'(CAL_ROUNDS)) begin
                                round_reg <= round_reg + 1'b1;
                            end
                            if (round_reg >= RW'(CAL_ROUNDS - 1)) begin
                                cal_done_reg <= 1'b1;
                            end
                        end
                    end else if (charge_tick) begin
                        count_reg <= count_inc;
                    end
                end
                RECORD: begin
                    // enable_i only matters at the end of a full round.
                    if (last_ch) begin
                        ch_reg <= '0;
                        if (enable_i) begin
                            state_reg <= DISCH;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        state_reg <= DISCH;
                        ch_reg    <= ch_reg + 1'b1;
                    end
                    tick_reg <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    oe_reg    <= '1;
                end
            endcase
        end
    end

    // Per-channel baseline and debouncer. Debouncers only see updates once
    // calibration is done, which keeps pressed_o at 0 until then.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [CNT_W-1:0] baseline_reg;
            logic             sel;

            assign sel = record_fire && (ch_reg == CH_W'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    baseline_reg <= '1;
                end else if (sel) begin
                    if (!cal_done_reg) begin
                        if (count_fin < baseline_reg) begin
                            baseline_reg <= count_fin;
                        end
                    end
`ifdef CAPSENSE_BASELINE_TRACK_EN
                    else if (!raw_cur && !pressed_vec[gi]) begin
                        if (count_fin > baseline_reg) begin
                            baseline_reg <= baseline_reg + 1'b1;
                        end else if (count_fin < baseline_reg) begin
                            baseline_reg <= baseline_reg - 1'b1;
                        end
                    end
`else
                    // Baseline stays frozen once calibration is done.
`endif
                end
            end

            assign baseline_vec[gi] = baseline_reg;

            capsense_debounce #(
                .DEB (DEB)
            ) u_deb (
                .clk     (clk_i),
                .rst_n   (rst_ni),
                .update  (sel && cal_done_reg),
                .raw     (raw_cur),
                .pressed (pressed_vec[gi])
            );
        end
    endgenerate

    assign capsense_oe_o = oe_reg;
    assign pressed_o     = pressed_vec;
    assign cnt_o         = cnt_reg;
    assign cnt_ch_o      = cnt_ch_reg;
    assign cnt_valid_o   = valid_reg;
    assign timeout_o     = timeout_reg;
    assign cal_done_o    = cal_done_reg;
    assign busy_o        = busy_reg;

endmodule
